// File: rtl/uat.sv
// uat: serial transmitter, start bit, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// A one-deep holding register lets frames run back to back. Even parity is built when UAT_PARITY_EN is defined.
module uat #(
   parameter int CLKS_PER_BIT = 8,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 gl_reset,
   input  logic [DATA_BITS-1:0] dIn,
   input  logic                 dLoad,
   output logic                 dReady,
   output logic                 dOut,
   output logic                 dBusy,
   output logic                 dOverrun
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(DATA_BITS + STOP_BITS + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

`ifdef UAT_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      even_parity = ^d;
   endfunction

   logic parity_r;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;
`endif

   state_t               state_r;
   logic [CW-1:0]        cnt_r;
   logic [BW-1:0]        bit_cnt_r;
   logic [DATA_BITS-1:0] hold_r;
   logic [DATA_BITS-1:0] shift_r;
   logic [DATA_BITS-1:0] shift_next_s;
   logic                 ready_r;
   logic                 out_r;
   logic                 busy_r;
   logic                 overrun_r;
   logic                 bit_end_s;
   logic                 launch_s;

   assign bit_end_s    = (cnt_r == CNT_LAST);
   assign shift_next_s = shift_r >> 1'b1;
   // A full hold register starts a frame from IDLE or straight out of the last stop cycle.
   assign launch_s     = !ready_r && ((state_r == S_IDLE) ||
                         ((state_r == S_STOP) && bit_end_s && (bit_cnt_r == STOP_LAST)));

   // Holding register, frame FSM and registered line outputs.
   always_ff @(posedge clk) begin
      if (gl_reset) begin
         state_r   <= S_IDLE;
         cnt_r     <= '0;
         bit_cnt_r <= '0;
         hold_r    <= '0;
         shift_r   <= '0;
         ready_r   <= 1'b1;
         out_r     <= 1'b1;
         busy_r    <= 1'b0;
         overrun_r <= 1'b0;
`ifdef UAT_PARITY_EN
         parity_r  <= 1'b0;
`endif
      end else begin
         overrun_r <= dLoad & ~ready_r;
         if (launch_s) begin
            state_r   <= S_START;
            shift_r   <= hold_r;
            ready_r   <= 1'b1;
            out_r     <= 1'b0;
            busy_r    <= 1'b1;
            cnt_r     <= '0;
            bit_cnt_r <= '0;
`ifdef UAT_PARITY_EN
            parity_r  <= even_parity(hold_r);
`endif
         end else begin
            if (dLoad && ready_r) begin
               hold_r  <= dIn;
               ready_r <= 1'b0;
            end
            case (state_r)
               S_IDLE: begin
                  out_r  <= 1'b1;
                  busy_r <= 1'b0;
                  cnt_r  <= '0;
               end
               S_START: begin
                  if (bit_end_s) begin
                     state_r <= S_DATA;
                     out_r   <= shift_r[0];
                     cnt_r   <= '0;
                  end else begin
                     cnt_r <= cnt_r + CW'(1);
                  end
               end
               S_DATA: begin
                  if (bit_end_s) begin
                     cnt_r <= '0;
                     if (bit_cnt_r == DATA_LAST) begin
                        bit_cnt_r <= '0;
`ifdef UAT_PARITY_EN
                        state_r   <= S_PARITY;
                        out_r     <= parity_r;
`else
                        state_r   <= S_STOP;
                        out_r     <= 1'b1;
`endif
                     end else begin
                        bit_cnt_r <= bit_cnt_r + BW'(1);
                        shift_r   <= shift_next_s;
                        out_r     <= shift_next_s[0];
                     end
                  end else begin
                     cnt_r <= cnt_r + CW'(1);
                  end
               end
`ifdef UAT_PARITY_EN
               S_PARITY: begin
                  if (bit_end_s) begin
                     state_r   <= S_STOP;
                     out_r     <= 1'b1;
                     cnt_r     <= '0;
                     bit_cnt_r <= '0;
                  end else begin
                     cnt_r <= cnt_r + CW'(1);
                  end
               end
`endif
               S_STOP: begin
                  if (bit_end_s) begin
                     cnt_r <= '0;
                     if (bit_cnt_r == STOP_LAST) begin
                        state_r   <= S_IDLE;
                        busy_r    <= 1'b0;
                        out_r     <= 1'b1;
                        bit_cnt_r <= '0;
                     end else begin
                        bit_cnt_r <= bit_cnt_r + BW'(1);
                     end
                  end else begin
                     cnt_r <= cnt_r + CW'(1);
                  end
               end
               default: begin
                  state_r <= S_IDLE;
                  out_r   <= 1'b1;
                  busy_r  <= 1'b0;
                  cnt_r   <= '0;
               end
            endcase
         end
      end
   end

   assign dReady   = ready_r;
   assign dOut     = out_r;
   assign dBusy    = busy_r;
   assign dOverrun = overrun_r;
endmodule
